// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the serial FIR multiply-accumulate stages:
//   - fir_state_t    : control state of the MAC sequencer (IDLE/MAC/DONE)
//   - fir_acc_width  : accumulator width that holds a full dot product
//                      without overflow
//   - FIR_COEFFS_*   : default 9-tap, 8-bit coefficient sets, one per
//                      wavelet band, packed with coef k at [k*8 +: 8]
// No ports (package).
// -----------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  // Product width plus enough guard bits for TOTAL_TAPS worst-case additions.
  function automatic int fir_acc_width(input int bits_per_tap,
                                       input int coef_bits,
                                       input int total_taps);
    return bits_per_tap + coef_bits + $clog2(total_taps);
  endfunction

  localparam int FIR_BAND_TAPS      = 9;
  localparam int FIR_BAND_COEF_BITS = 8;

  // Symmetric sets, so tap ordering inside the vector does not matter.
  // Low band: 1, 4, 12, 22, 26, 22, 12, 4, 1
  localparam logic [FIR_BAND_TAPS*FIR_BAND_COEF_BITS-1:0] FIR_COEFFS_LOW =
    72'h01_04_0C_16_1A_16_0C_04_01;
  // High band: -1, -4, -12, -22, 78, -22, -12, -4, -1
  localparam logic [FIR_BAND_TAPS*FIR_BAND_COEF_BITS-1:0] FIR_COEFFS_HIGH =
    72'hFF_FC_F4_EA_4E_EA_F4_FC_FF;
  // Mid band: -2, 0, 18, 0, 32, 0, 18, 0, -2
  localparam logic [FIR_BAND_TAPS*FIR_BAND_COEF_BITS-1:0] FIR_COEFFS_MID =
    72'hFE_00_12_00_20_00_12_00_FE;

endpackage

// File: rtl/fir_tap_mult.sv
// -----------------------------------------------------------------------------
// fir_tap_mult
// Purely combinational signed A_BITS x B_BITS multiplier whose product is
// sign-extended to P_BITS (the accumulator width of the caller).
// Ports:
//   i_a  in  A_BITS  signed multiplicand (tap sample)
//   i_b  in  B_BITS  signed multiplier (coefficient)
//   o_p  out P_BITS  signed product, sign-extended
// P_BITS must be at least A_BITS+B_BITS.
// -----------------------------------------------------------------------------
module fir_tap_mult #(
  parameter int A_BITS = 8,
  parameter int B_BITS = 8,
  parameter int P_BITS = 20
) (
  input  logic [A_BITS-1:0] i_a,
  input  logic [B_BITS-1:0] i_b,
  output logic [P_BITS-1:0] o_p
);

  localparam int M_BITS = A_BITS + B_BITS;

  // Operands are widened to the full product width first so the multiply is
  // carried out at M_BITS and its low M_BITS bits are the exact product.
  logic signed [M_BITS-1:0] w_a_ext;
  logic signed [M_BITS-1:0] w_b_ext;
  logic signed [M_BITS-1:0] w_prod;

  assign w_a_ext = {{B_BITS{i_a[A_BITS-1]}}, i_a};
  assign w_b_ext = {{A_BITS{i_b[B_BITS-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  generate
    if (P_BITS > M_BITS) begin : g_ext
      assign o_p = {{(P_BITS-M_BITS){w_prod[M_BITS-1]}}, w_prod};
    end else begin : g_same
      assign o_p = w_prod[P_BITS-1:0];
    end
  endgenerate

endmodule

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Serial multiply-accumulate FIR stage. A start pulse snapshots the whole tap
// vector; the dot product with the fixed COEFFS set is then accumulated one
// tap per cycle, arithmetically shifted right by SHIFT, clipped to OUT_BITS
// and registered with a one-cycle valid strobe.
//
// Build option:
//   FIR_SATURATE_EN defined   : shifted result clamps to the OUT_BITS range
//   FIR_SATURATE_EN undefined : shifted result wraps to its low OUT_BITS bits
//
// Ports:
//   clk           in  1           rising-edge clock
//   reset         in  1           synchronous active-high reset
//   i_taps        in  TOTAL_BITS  tap k at [k*BITS_PER_TAP +: BITS_PER_TAP]
//   i_start_calc  in  1           pulse: taps valid, begin a computation
//   o_value       out OUT_BITS    signed result, held until the next one
//   o_valid       out 1           pulse: o_value updated
//   o_busy        out 1           high while accumulating
//   o_overrun     out 1           pulse: a start arrived while busy, dropped
// -----------------------------------------------------------------------------
module fir_mac
  import fir_pkg::*;
#(
  parameter int TOTAL_TAPS   = 9,
  parameter int BITS_PER_TAP = 8,
  parameter int TOTAL_BITS   = TOTAL_TAPS * BITS_PER_TAP,
  parameter int COEF_BITS    = 8,
  parameter logic [TOTAL_TAPS*COEF_BITS-1:0] COEFFS = '0,
  parameter int OUT_BITS     = 16,
  parameter int SHIFT        = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TOTAL_BITS-1:0] i_taps,
  input  logic                  i_start_calc,
  output logic [OUT_BITS-1:0]   o_value,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int ACC_W  = fir_acc_width(BITS_PER_TAP, COEF_BITS, TOTAL_TAPS);
  localparam int IDX_W  = (TOTAL_TAPS > 1) ? $clog2(TOTAL_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_TAPS - 1);
  // One bit wider than both the accumulator and the output, so the clamp
  // comparisons are exact whichever of the two is wider.
  localparam int WIDE_W = ((ACC_W > OUT_BITS) ? ACC_W : OUT_BITS) + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fir_state_t              r_state;
  logic [TOTAL_BITS-1:0]   r_taps;
  logic signed [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic [OUT_BITS-1:0]     r_value;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_overrun;

  // ---------------------------------------------------------------------------
  // Tap / coefficient selection for the current index
  // ---------------------------------------------------------------------------
  logic [BITS_PER_TAP-1:0] w_tap_arr  [TOTAL_TAPS];
  logic [COEF_BITS-1:0]    w_coef_arr [TOTAL_TAPS];

  generate
    for (genvar gi = 0; gi < TOTAL_TAPS; gi++) begin : g_unpack
      assign w_tap_arr[gi]  = r_taps[gi*BITS_PER_TAP +: BITS_PER_TAP];
      assign w_coef_arr[gi] = COEFFS[gi*COEF_BITS +: COEF_BITS];
    end
  endgenerate

  logic [BITS_PER_TAP-1:0] w_cur_tap;
  logic [COEF_BITS-1:0]    w_cur_coef;
  logic [ACC_W-1:0]        w_prod;

  assign w_cur_tap  = w_tap_arr[r_idx];
  assign w_cur_coef = w_coef_arr[r_idx];

  fir_tap_mult #(
    .A_BITS (BITS_PER_TAP),
    .B_BITS (COEF_BITS),
    .P_BITS (ACC_W)
  ) u_tap_mult (
    .i_a (w_cur_tap),
    .i_b (w_cur_coef),
    .o_p (w_prod)
  );

  // ---------------------------------------------------------------------------
  // Scale and clip
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [WIDE_W-1:0] w_wide;
  logic [OUT_BITS-1:0]      w_clip;

  assign w_shifted = r_acc >>> SHIFT;
  assign w_wide    = {{(WIDE_W-ACC_W){w_shifted[ACC_W-1]}}, w_shifted};

`ifdef FIR_SATURATE_EN
  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    {{(WIDE_W-OUT_BITS){1'b0}}, 1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN =
    {{(WIDE_W-OUT_BITS){1'b1}}, 1'b1, {(OUT_BITS-1){1'b0}}};

  always_comb begin
    w_clip = w_wide[OUT_BITS-1:0];
    if (w_wide > SAT_MAX) begin
      w_clip = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else if (w_wide < SAT_MIN) begin
      w_clip = {1'b1, {(OUT_BITS-1){1'b0}}};
    end
  end
`else
  // Wrap: the bits above OUT_BITS are intentionally discarded.
  logic w_unused_wide_hi;
  assign w_unused_wide_hi = ^w_wide[WIDE_W-1:OUT_BITS];
  assign w_clip           = w_wide[OUT_BITS-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_taps    <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start_calc) begin
            r_taps  <= i_taps;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= r_acc + $signed(w_prod);
          r_idx <= r_idx + IDX_W'(1);
          // A start here is dropped; the snapshot and accumulator are kept.
          if (i_start_calc) begin
            r_overrun <= 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_value <= w_clip;
          r_valid <= 1'b1;
          // Accepting a start here gives back-to-back operation.
          if (i_start_calc) begin
            r_taps  <= i_taps;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_value   = r_value;
  assign o_valid   = r_valid;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_fir_mac.sv
// -----------------------------------------------------------------------------
// tb_fir_mac
// Four fir_mac instances with different coefficient sets and shifts share one
// tap line, start and reset, mirroring the multi-band arrangement. Directed
// sequences with hand-computed results.
// -----------------------------------------------------------------------------
module tb_fir_mac;

  localparam logic [71:0] COEF_RAMP = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5,
                                       8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] COEF_ONES = {9{8'd1}};
  localparam logic [71:0] COEF_BIG  = {9{8'd127}};

  localparam logic [71:0] TAPS_ZERO = 72'h0;
  localparam logic [71:0] TAPS_IMP  = 72'h1 << 32;
  localparam logic [71:0] TAPS_ONES = {9{8'd1}};
  localparam logic [71:0] TAPS_IDX  = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4,
                                       8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] TAPS_POS  = {9{8'd127}};
  localparam logic [71:0] TAPS_NEG  = {9{8'h80}};

`ifdef FIR_SATURATE_EN
  localparam longint BIG_POS = 32767;
  localparam longint BIG_NEG = -32768;
`else
  localparam longint BIG_POS = 14089;
  localparam longint BIG_NEG = -15232;
`endif

  logic        clk;
  logic        reset;
  logic [71:0] taps;
  logic        start;

  logic signed [15:0] val_ramp, val_ones, val_s2, val_big;
  logic [3:0] valid_v, busy_v, ovr_v;

  int n_err = 0;
  int n_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fir_mac #(.COEFFS(COEF_RAMP), .SHIFT(0)) u_ramp (
    .clk(clk), .reset(reset), .i_taps(taps), .i_start_calc(start),
    .o_value(val_ramp), .o_valid(valid_v[0]), .o_busy(busy_v[0]), .o_overrun(ovr_v[0]));
  fir_mac #(.COEFFS(COEF_ONES), .SHIFT(0)) u_ones (
    .clk(clk), .reset(reset), .i_taps(taps), .i_start_calc(start),
    .o_value(val_ones), .o_valid(valid_v[1]), .o_busy(busy_v[1]), .o_overrun(ovr_v[1]));
  fir_mac #(.COEFFS(COEF_ONES), .SHIFT(2)) u_ones_s2 (
    .clk(clk), .reset(reset), .i_taps(taps), .i_start_calc(start),
    .o_value(val_s2), .o_valid(valid_v[2]), .o_busy(busy_v[2]), .o_overrun(ovr_v[2]));
  fir_mac #(.COEFFS(COEF_BIG), .SHIFT(0)) u_big (
    .clk(clk), .reset(reset), .i_taps(taps), .i_start_calc(start),
    .o_value(val_big), .o_valid(valid_v[3]), .o_busy(busy_v[3]), .o_overrun(ovr_v[3]));

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One computation, observed at every negedge for 'window' cycles.
  // e = number of posedges after the start edge t0 (e=0 is just after t0).
  // start2/rst/chg give the edge (relative to t0) at which a second start,
  // a reset, or a tap change is sampled; -1 disables.
  task automatic run_seq(input string tag, input logic [71:0] taps_a,
                         input logic [71:0] taps_b, input int chg_edge,
                         input int start2_edge, input int rst_edge,
                         input int window,
                         input int e_vcnt, input int e_v1, input int e_v2,
                         input int e_busy, input int e_ocnt, input int e_o1,
                         input longint e_ramp, input longint e_ones,
                         input longint e_s2, input longint e_big,
                         input longint e_ramp2);
    int     vcnt = 0, v1 = -1, v2 = -1, bcnt = 0, ocnt = 0, o1 = -1, desync = 0;
    longint c_ramp = 0, c_ones = 0, c_s2 = 0, c_big = 0, c_ramp2 = 0;
    logic [18:0] rst_obs = '1;
    @(negedge clk);
    taps  = taps_a;
    start = 1'b1;
    for (int e = 0; e < window; e++) begin
      @(negedge clk);
      if (valid_v != {4{valid_v[0]}} || busy_v != {4{busy_v[0]}} ||
          ovr_v != {4{ovr_v[0]}})
        desync++;
      if (busy_v[0]) bcnt++;
      if (ovr_v[0]) begin
        ocnt++;
        if (o1 < 0) o1 = e;
      end
      if (valid_v[0]) begin
        vcnt++;
        if (v1 < 0) begin
          v1 = e;
          c_ramp = val_ramp; c_ones = val_ones; c_s2 = val_s2; c_big = val_big;
        end else if (v2 < 0) begin
          v2 = e;
          c_ramp2 = val_ramp;
        end
      end
      if (e == rst_edge)
        rst_obs = {val_ramp, valid_v[0], busy_v[0], ovr_v[0]};
      start = (e + 1 == start2_edge);
      reset = (e + 1 == rst_edge);
      if (e + 1 == chg_edge) taps = taps_b;
    end
    start = 1'b0;
    reset = 1'b0;
    $display("[%s] valids=%0d first@%0d second@%0d busy=%0d overruns=%0d value=%0d/%0d/%0d/%0d",
             tag, vcnt, v1, v2, bcnt, ocnt, c_ramp, c_ones, c_s2, c_big);
    check({tag, ".valid_count"}, vcnt, e_vcnt);
    check({tag, ".valid_edge1"}, v1, e_v1);
    check({tag, ".valid_edge2"}, v2, e_v2);
    check({tag, ".busy_cycles"}, bcnt, e_busy);
    check({tag, ".overrun_count"}, ocnt, e_ocnt);
    check({tag, ".overrun_edge"}, o1, e_o1);
    check({tag, ".band_sync"}, desync, 0);
    if (e_vcnt > 0) begin
      check({tag, ".ramp"}, c_ramp, e_ramp);
      check({tag, ".ones"}, c_ones, e_ones);
      check({tag, ".ones_s2"}, c_s2, e_s2);
      check({tag, ".big"}, c_big, e_big);
    end
    if (e_vcnt > 1) check({tag, ".ramp2"}, c_ramp2, e_ramp2);
    if (rst_edge >= 0) check({tag, ".after_reset"}, longint'(rst_obs), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    taps  = TAPS_ZERO;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[reset] value=%0d valid=%b busy=%b overrun=%b",
             val_ramp, valid_v, busy_v, ovr_v);
    check("reset.value_ramp", val_ramp, 0);
    check("reset.value_big", val_big, 0);
    check("reset.valid", valid_v, 0);
    check("reset.busy", busy_v, 0);
    check("reset.overrun", ovr_v, 0);

    //      tag       taps_a     taps_b     chg  s2  rst win vc v1  v2  busy oc o1   ramp   ones   s2    big     ramp2
    run_seq("impulse", TAPS_IMP,  TAPS_ZERO, -1, -1, -1, 14, 1, 10, -1, 9,  0, -1, 5,     1,     0,    127,    0);
    run_seq("ones",    TAPS_ONES, TAPS_ZERO, -1, -1, -1, 14, 1, 10, -1, 9,  0, -1, 45,    9,     2,    1143,   0);
    run_seq("index",   TAPS_IDX,  TAPS_ZERO, -1, -1, -1, 14, 1, 10, -1, 9,  0, -1, 240,   36,    9,    4572,   0);
    run_seq("clippos", TAPS_POS,  TAPS_ZERO, -1, -1, -1, 14, 1, 10, -1, 9,  0, -1, 5715,  1143,  285,  BIG_POS, 0);
    run_seq("clipneg", TAPS_NEG,  TAPS_ZERO, -1, -1, -1, 14, 1, 10, -1, 9,  0, -1, -5760, -1152, -288, BIG_NEG, 0);
    run_seq("snapshot",TAPS_ONES, TAPS_POS,   3, -1, -1, 14, 1, 10, -1, 9,  0, -1, 45,    9,     2,    1143,   0);
    run_seq("overrun", TAPS_IMP,  TAPS_ONES,  4,  4, -1, 14, 1, 10, -1, 9,  1,  4, 5,     1,     0,    127,    0);
    run_seq("b2b",     TAPS_IDX,  TAPS_ONES, 10, 10, -1, 24, 2, 10, 20, 18, 0, -1, 240,   36,    9,    4572,   45);
    run_seq("rstmac",  TAPS_ONES, TAPS_ZERO, -1, -1,  5, 14, 0, -1, -1, 5,  0, -1, 0,     0,     0,    0,      0);
    run_seq("rststart",TAPS_IDX,  TAPS_ZERO, -1,  5,  5, 14, 0, -1, -1, 5,  0, -1, 0,     0,     0,    0,      0);
    run_seq("recover", TAPS_IDX,  TAPS_ZERO, -1, -1, -1, 14, 1, 10, -1, 9,  0, -1, 240,   36,    9,    4572,   0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
